// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Contents:
//   WORD_WIDTH / REG_IDX_W / NUM_REGS : datapath and register-index widths
//   arb_state_e : arbiter FSM state (IDLE / PEND / FORCE)
//   aux_entry_t : one queued auxiliary result {dest, value}
//   dest_onehot : register index -> one-hot register mask
package wb_port_arbiter_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int REG_IDX_W  = 4;
  localparam int NUM_REGS   = 1 << REG_IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // FIFO empty
    ST_PEND  = 2'd1,  // FIFO holds at least one entry
    ST_FORCE = 2'd2   // one-cycle starvation drain, pipeline frozen
  } arb_state_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0]  dest;
    logic [WORD_WIDTH-1:0] value;
  } aux_entry_t;

  function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [REG_IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline / auxiliary unit and the write-port arbiter.
// Signals:
//   wb_en_in, wb_dest_in, wb_value_in : pipeline writeback request
//   aux_valid, aux_dest, aux_value    : auxiliary result offer
//   aux_ready                         : arbiter can queue an auxiliary result
//   rf_we, rf_dest, rf_value          : register-file write port
//   pipe_freeze                       : pipeline must hold all stages this cycle
//   pend_mask                         : registers targeted by queued aux results
// Modports: slave = arbiter side, master = pipeline / aux-unit side.
//
// Handshake: an auxiliary result transfers on a rising clock edge where
// aux_valid and aux_ready are both 1. aux_ready depends only on registered
// arbiter state, never on aux_valid, so the producer may look at it before
// deciding to offer. While aux_valid=1 and aux_ready=0 the producer keeps
// aux_dest/aux_value stable until the transfer happens.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic                  wb_en_in;
  logic [REG_IDX_W-1:0]  wb_dest_in;
  logic [WORD_WIDTH-1:0] wb_value_in;
  logic                  aux_valid;
  logic [REG_IDX_W-1:0]  aux_dest;
  logic [WORD_WIDTH-1:0] aux_value;
  logic                  aux_ready;
  logic                  rf_we;
  logic [REG_IDX_W-1:0]  rf_dest;
  logic [WORD_WIDTH-1:0] rf_value;
  logic                  pipe_freeze;
  logic [NUM_REGS-1:0]   pend_mask;

  modport slave (
    input  wb_en_in, wb_dest_in, wb_value_in,
    input  aux_valid, aux_dest, aux_value,
    output aux_ready,
    output rf_we, rf_dest, rf_value,
    output pipe_freeze, pend_mask
  );

  modport master (
    output wb_en_in, wb_dest_in, wb_value_in,
    output aux_valid, aux_dest, aux_value,
    input  aux_ready,
    input  rf_we, rf_dest, rf_value,
    input  pipe_freeze, pend_mask
  );

endinterface

// File: rtl/wb_aux_fifo.sv
// Synchronous FIFO holding auxiliary results waiting for a free write slot.
// Ports:
//   clk, rst      : clock, synchronous active-low reset (drops all entries)
//   push          : enqueue push_entry at this edge
//   push_entry    : {dest, value} to enqueue
//   pop           : dequeue the head at this edge
//   head          : current head entry (valid when count != 0)
//   count         : number of occupied entries (registered)
//   entry_valid   : per-slot occupancy, indexed by physical slot
//   entry_dest    : per-slot destination register, indexed by physical slot
// Push and pop in the same cycle are accepted at any fill level; a push into
// a full FIFO without a pop and a pop from an empty FIFO are ignored.
module wb_aux_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  aux_entry_t                         push_entry,
  input  logic                               pop,
  output aux_entry_t                         head,
  output logic [CNT_W-1:0]                   count,
  output logic [DEPTH-1:0]                   entry_valid,
  output logic [DEPTH-1:0][REG_IDX_W-1:0]    entry_dest
);

  aux_entry_t       mem_q [DEPTH];
  aux_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // When full, the write slot equals the read slot; a simultaneous pop reads
  // the old head combinationally before the edge overwrites it.
  assign push_ok = push && ((count_q != CNT_W'(DEPTH)) || pop);
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: occupancy is tracked solely by count/pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // A physical slot is occupied when its distance from the read pointer,
  // modulo DEPTH, is below the occupancy count.
  always_comb begin
    logic [PTR_W-1:0] off;
    entry_valid = '0;
    entry_dest  = '0;
    off         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PTR_W'(i) - rd_ptr_q;
      entry_valid[i] = (CNT_W'(off) < count_q);
      entry_dest[i]  = mem_q[i].dest;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the pipeline writeback and an
// auxiliary multi-cycle result source.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   bus        : wb_port_arbiter_if.slave (writeback in, aux in/ready,
//                register-file write port, pipe_freeze, pend_mask)
//   dbg_state  : current arbiter FSM state
//   dbg_count  : current auxiliary FIFO occupancy
// Grant order each cycle: forced drain (FORCE state) > pipeline writeback >
// FIFO head. Aux results always pass through the FIFO, so they reach the
// register file no earlier than the cycle after they are accepted.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter  int DEPTH    = 2,
  parameter  int MAX_WAIT = 4,
  localparam int CNT_W    = $clog2(DEPTH) + 1,
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  wb_port_arbiter_if.slave        bus,
  output arb_state_e              dbg_state,
  output logic [CNT_W-1:0]        dbg_count
);

  arb_state_e                     state_q, state_d;
  logic [WAIT_W-1:0]              wait_q, wait_d;

  logic                           aux_ready;
  logic                           push;
  logic                           pop;
  aux_entry_t                     push_entry;
  aux_entry_t                     head;
  logic [CNT_W-1:0]               count;
  logic [CNT_W-1:0]               count_next;
  logic                           fifo_empty;
  logic [DEPTH-1:0]               entry_valid;
  logic [DEPTH-1:0][REG_IDX_W-1:0] entry_dest;

  logic                           rf_we;
  logic [REG_IDX_W-1:0]           rf_dest;
  logic [WORD_WIDTH-1:0]          rf_value;
  logic                           pipe_freeze;
  logic [NUM_REGS-1:0]            pend_mask;

  // Readiness comes from registered occupancy only, and is held low in reset.
  assign aux_ready        = rst && (count != CNT_W'(DEPTH));
  assign push             = bus.aux_valid && aux_ready;
  assign push_entry.dest  = bus.aux_dest;
  assign push_entry.value = bus.aux_value;
  assign fifo_empty       = (count == '0);

  wb_aux_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_dest  (entry_dest)
  );

  // Grant mux. In FORCE the WB inputs are ignored; pipe_freeze makes the
  // pipeline present the same writeback again next cycle, so nothing is lost.
  always_comb begin
    rf_we       = 1'b0;
    rf_dest     = '0;
    rf_value    = '0;
    pop         = 1'b0;
    pipe_freeze = 1'b0;
    if (rst) begin
      if (state_q == ST_FORCE && !fifo_empty) begin
        rf_we       = 1'b1;
        rf_dest     = head.dest;
        rf_value    = head.value;
        pop         = 1'b1;
        pipe_freeze = 1'b1;
      end else if (bus.wb_en_in) begin
        rf_we    = 1'b1;
        rf_dest  = bus.wb_dest_in;
        rf_value = bus.wb_value_in;
      end else if (!fifo_empty) begin
        rf_we    = 1'b1;
        rf_dest  = head.dest;
        rf_value = head.value;
        pop      = 1'b1;
      end
    end
  end

  // Next-state, starvation counter. wait_q counts consecutive cycles the
  // current head has sat unserved; it restarts whenever any entry drains.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    count_next = count + CNT_W'(push) - CNT_W'(pop);

    if (pop || fifo_empty) begin
      wait_d = '0;
    end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (push) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (count_next == '0) begin
          state_d = ST_IDLE;
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1) && !pop) begin
          state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        state_d = (count_next == '0) ? ST_IDLE : ST_PEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Registered FIFO view only: a popped entry's bit drops the cycle after.
  always_comb begin
    pend_mask = '0;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_valid[i]) pend_mask = pend_mask | dest_onehot(entry_dest[i]);
      end
    end
  end

  assign bus.aux_ready   = aux_ready;
  assign bus.rf_we       = rf_we;
  assign bus.rf_dest     = rf_dest;
  assign bus.rf_value    = rf_value;
  assign bus.pipe_freeze = pipe_freeze;
  assign bus.pend_mask   = pend_mask;
  assign dbg_state       = state_q;
  assign dbg_count       = count;

endmodule
